// File: rtl/regfile_port_sequencer.sv
// Register-file port sequencer: owns the single shared register-file port,
// fetches rs1 then rs2 over it, and slots single-cycle write-backs into the
// cycles where the port is not busy reading. Operands are presented as a
// registered pair to the execute stage through a valid/ready handshake.
module regfile_port_sequencer #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_rs1,
    input  logic [IDX_W-1:0] req_rs2,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [XLEN-1:0]  op_a,
    output logic [XLEN-1:0]  op_b,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [IDX_W-1:0] rf_idx,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             rf_we,
    input  logic [XLEN-1:0]  rf_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ1 = 2'd1,
        READ2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rs1_q, rs1_d;
    logic [IDX_W-1:0]  rs2_q, rs2_d;
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic              op_valid_q, op_valid_d;

    // The port is free for a write-back only when no operand read is in flight.
    logic wb_slot;
    assign wb_slot = (state_q == IDLE) || (state_q == DONE);

    // State and datapath registers; reset abandons any in-flight fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
        end
    end

    // Next-state: accept, read rs1, read rs2, then hold operands until consumed.
    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    state_d = READ1;
                end
            end
            READ1: begin
                op_a_d  = rf_rdata;
                state_d = READ2;
            end
            READ2: begin
                op_b_d     = rf_rdata;
                op_valid_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                // Write-backs landing here deliberately leave op_a/op_b alone;
                // forwarding is the execute stage's responsibility.
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port outputs: write-back wins the port in IDLE so a same-cycle RAW
    // request is deferred one cycle and then reads the freshly written value.
    always_comb begin
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        rf_idx    = '0;
        rf_wdata  = wb_data;
        rf_we     = 1'b0;
        if (!rst) begin
            req_ready = (state_q == IDLE) && !wb_valid;
            if (wb_slot && wb_valid) begin
                wb_ready = 1'b1;
                rf_idx   = wb_rd;
                rf_we    = (wb_rd != '0);
            end
        end
        if (state_q == READ1) begin
            rf_idx = rs1_q;
        end else if (state_q == READ2) begin
            rf_idx = rs2_q;
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer with a behavioural register file
// attached to the shared port (combinational read, x0 reads as zero).
module tb_regfile_port_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rf_idx;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic [31:0] rf_rdata;

    logic        rf_clr;
    logic [31:0] rf_mem [32];

    int checks = 0;
    int errors = 0;

    regfile_port_sequencer #(.XLEN(32), .IDX_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rf_idx    (rf_idx),
        .rf_wdata  (rf_wdata),
        .rf_we     (rf_we),
        .rf_rdata  (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model
    assign rf_rdata = (rf_idx == 5'd0) ? 32'h0 : rf_mem[rf_idx];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
        end else if (rf_we) begin
            rf_mem[rf_idx] <= rf_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One write-back in IDLE/DONE with no request pending.
    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        req_valid = 1'b0;
        op_ready  = 1'b0;
        wb_valid  = 1'b1;
        wb_rd     = rd;
        wb_data   = data;
        #1;
        check_eq("wb_ready", {31'b0, wb_ready}, 32'd1);
        check_eq("wb_rf_we", {31'b0, rf_we}, {31'b0, (rd != 5'd0)});
        check_eq("wb_rf_idx", {27'b0, rf_idx}, {27'b0, rd});
        $display("wb rd=%0d data=%h we=%0b", rd, data, rf_we);
    endtask

    // Accept a request and walk through READ1/READ2 while a write-back is
    // pending (it must be refused while the port is reading).
    task automatic start_fetch(input logic [4:0] rs1, input logic [4:0] rs2);
        @(negedge clk);
        wb_valid  = 1'b0;
        op_ready  = 1'b0;
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        #1;
        check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        wb_valid  = 1'b1;
        wb_rd     = 5'd9;
        wb_data   = 32'h5A5A5A5A;
        #1;
        check_eq("read1_idx", {27'b0, rf_idx}, {27'b0, rs1});
        check_eq("read1_we", {31'b0, rf_we}, 32'd0);
        check_eq("read1_wb_ready", {31'b0, wb_ready}, 32'd0);
        check_eq("read1_op_valid", {31'b0, op_valid}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("read2_idx", {27'b0, rf_idx}, {27'b0, rs2});
        check_eq("read2_we", {31'b0, rf_we}, 32'd0);
        check_eq("read2_wb_ready", {31'b0, wb_ready}, 32'd0);
        check_eq("read2_op_valid", {31'b0, op_valid}, 32'd0);
    endtask

    // Check the presented operands, consume them, and confirm return to IDLE.
    task automatic finish_fetch(input logic [31:0] exp_a, input logic [31:0] exp_b);
        @(negedge clk);
        wb_valid = 1'b0;
        op_ready = 1'b1;
        #1;
        check_eq("done_op_valid", {31'b0, op_valid}, 32'd1);
        check_eq("done_op_a", op_a, exp_a);
        check_eq("done_op_b", op_b, exp_b);
        check_eq("done_req_ready", {31'b0, req_ready}, 32'd0);
        $display("fetch rs1=%0d rs2=%0d op_a=%h op_b=%h", dut.rs1_q, dut.rs2_q, op_a, op_b);
        @(negedge clk);
        op_ready = 1'b0;
        #1;
        check_eq("after_op_valid", {31'b0, op_valid}, 32'd0);
        check_eq("after_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    int we_pulses;

    initial begin
        rst       = 1'b1;
        rf_clr    = 1'b1;
        req_valid = 1'b0;
        req_rs1   = 5'd0;
        req_rs2   = 5'd0;
        op_ready  = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'h0;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_rf_we", {31'b0, rf_we}, 32'd0);
        check_eq("rst_op_valid", {31'b0, op_valid}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        rf_clr = 1'b0;
        #1;
        check_eq("reset_op_valid", {31'b0, op_valid}, 32'd0);
        check_eq("reset_op_a", op_a, 32'h0);
        check_eq("reset_op_b", op_b, 32'h0);
        check_eq("reset_rf_we", {31'b0, rf_we}, 32'd0);
        check_eq("reset_req_ready", {31'b0, req_ready}, 32'd1);
        $display("reset released");

        // Preload and basic fetch
        wb_write(5'd3, 32'h11);
        wb_write(5'd7, 32'h22);
        start_fetch(5'd3, 5'd7);
        finish_fetch(32'h11, 32'h22);

        // Same-cycle write-back and request: write-back wins, request waits
        @(negedge clk);
        wb_valid  = 1'b1;
        wb_rd     = 5'd5;
        wb_data   = 32'hDEADBEEF;
        req_valid = 1'b1;
        req_rs1   = 5'd5;
        req_rs2   = 5'd0;
        #1;
        check_eq("raw_wb_ready", {31'b0, wb_ready}, 32'd1);
        check_eq("raw_req_ready", {31'b0, req_ready}, 32'd0);
        check_eq("raw_rf_we", {31'b0, rf_we}, 32'd1);
        check_eq("raw_rf_idx", {27'b0, rf_idx}, 32'd5);
        $display("wb rd=5 data=deadbeef with req rs1=5 pending");
        start_fetch(5'd5, 5'd0);
        finish_fetch(32'hDEADBEEF, 32'h0);

        // Backpressure in DONE with a write-back to x3 during the stall
        start_fetch(5'd3, 5'd7);
        we_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_ready = 1'b0;
            wb_valid = (i == 1);
            wb_rd    = 5'd3;
            wb_data  = 32'h99;
            #1;
            check_eq("hold_op_valid", {31'b0, op_valid}, 32'd1);
            check_eq("hold_op_a", op_a, 32'h11);
            check_eq("hold_op_b", op_b, 32'h22);
            check_eq("hold_wb_ready", {31'b0, wb_ready}, {31'b0, (i == 1)});
            if (rf_we) we_pulses++;
        end
        check_eq("hold_we_pulses", we_pulses, 32'd1);
        $display("stall 5 cycles we_pulses=%0d", we_pulses);
        finish_fetch(32'h11, 32'h22);
        start_fetch(5'd3, 5'd3);
        finish_fetch(32'h99, 32'h99);

        // Write-back to x0 handshakes without a write
        wb_write(5'd0, 32'hFFFFFFFF);
        start_fetch(5'd0, 5'd7);
        finish_fetch(32'h0, 32'h22);

        // Reset during READ2
        @(negedge clk);
        wb_valid  = 1'b0;
        req_valid = 1'b1;
        req_rs1   = 5'd7;
        req_rs2   = 5'd3;
        #1;
        check_eq("mid_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check_eq("mid_read1_idx", {27'b0, rf_idx}, 32'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_we", {31'b0, rf_we}, 32'd0);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        wb_data  = 32'h77;
        #1;
        check_eq("mid_rst_wb_we", {31'b0, rf_we}, 32'd0);
        check_eq("mid_rst_op_valid", {31'b0, op_valid}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        wb_valid = 1'b0;
        #1;
        check_eq("post_rst_op_valid", {31'b0, op_valid}, 32'd0);
        check_eq("post_rst_op_a", op_a, 32'h0);
        check_eq("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        $display("reset during READ2 abandoned fetch");
        start_fetch(5'd4, 5'd7);
        finish_fetch(32'h0, 32'h22);
        start_fetch(5'd7, 5'd3);
        finish_fetch(32'h22, 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
